// File: rtl/arcade_input_mapper_if.sv
// Purpose : HPS-side input bundle and core-side control outputs of the arcade input mapper.
// Ports   : ps2_key/joy1/joy2 flow from hps_io (master) into the mapper (slave);
//           m_* controls and key_state flow back out of the mapper.
interface arcade_input_mapper_if;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        m_right;
  logic        m_left;
  logic        m_down;
  logic        m_up;
  logic        m_fire;
  logic        m_start1;
  logic        m_start2;
  logic        m_coin;
  logic [15:0] key_state;

  modport master (
    output ps2_key, joy1, joy2,
    input  m_right, m_left, m_down, m_up, m_fire,
    input  m_start1, m_start2, m_coin, key_state
  );

  modport slave (
    input  ps2_key, joy1, joy2,
    output m_right, m_left, m_down, m_up, m_fire,
    output m_start1, m_start2, m_coin, key_state
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Purpose : map PS/2 key events and two joysticks onto popeye control inputs; shape coin.
// Latency : key_state one cycle after the toggle event; m_coin one cycle after coin rise;
//           direction/start outputs combinational from key_state and joysticks.
// Backpr. : none -- inputs are levels/toggles and are consumed every cycle.
// Ports   : clk_sys, reset (sync, active-high); io.slave carries ps2_key, joy1, joy2 in
//           and m_right/left/down/up/fire, m_start1/2, m_coin, key_state out.
module arcade_input_mapper #(
  parameter int COIN_PULSE = 2000000,
  parameter int COIN_GAP   = 2000000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  arcade_input_mapper_if.slave  io
);

  localparam logic [23:0] PULSE_LOAD = 24'(COIN_PULSE - 1);
  localparam logic [23:0] GAP_LOAD   = 24'(COIN_GAP - 1);

  // ---------------------------------------------------------------------------
  // Keyboard event detection and key state
  // ---------------------------------------------------------------------------
  logic        tog_q;
  logic        key_event;
  logic [13:0] key_mask;
  logic [13:0] ks_q;

  // hps_io flips bit 10 once per key event, so any difference from last cycle
  // marks exactly one event.
  assign key_event = io.ps2_key[10] ^ tog_q;

  // One-hot target bit for the scan code; zero for unmapped codes so they
  // leave the state untouched. Bit 8 (extended) is deliberately not decoded.
  always_comb begin
    key_mask = '0;
    case (io.ps2_key[7:0])
      8'h74:        key_mask = 14'h0001;  // R1
      8'h6B:        key_mask = 14'h0002;  // L1
      8'h72:        key_mask = 14'h0004;  // D1
      8'h75:        key_mask = 14'h0008;  // U1
      8'h14:        key_mask = 14'h0010;  // fire1
      8'h05, 8'h16: key_mask = 14'h0020;  // start1
      8'h06, 8'h1E: key_mask = 14'h0040;  // start2
      8'h76, 8'h2E: key_mask = 14'h0080;  // coin1
      8'h36:        key_mask = 14'h0100;  // coin2
      8'h34:        key_mask = 14'h0200;  // R2
      8'h23:        key_mask = 14'h0400;  // L2
      8'h2B:        key_mask = 14'h0800;  // D2
      8'h2D:        key_mask = 14'h1000;  // U2
      8'h1C:        key_mask = 14'h2000;  // fire2
      default:      key_mask = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q <= 1'b0;
      ks_q  <= '0;
    end else begin
      tog_q <= io.ps2_key[10];
      if (key_event) begin
        ks_q <= (ks_q & ~key_mask) | ({14{io.ps2_key[9]}} & key_mask);
      end
    end
  end

  assign io.key_state = {2'b00, ks_q};

  // ---------------------------------------------------------------------------
  // Merged player controls (P1 and P2 share the single cabinet control set)
  // ---------------------------------------------------------------------------
  assign io.m_right  = ks_q[0] | ks_q[9]  | io.joy1[0] | io.joy2[0];
  assign io.m_left   = ks_q[1] | ks_q[10] | io.joy1[1] | io.joy2[1];
  assign io.m_down   = ks_q[2] | ks_q[11] | io.joy1[2] | io.joy2[2];
  assign io.m_up     = ks_q[3] | ks_q[12] | io.joy1[3] | io.joy2[3];
  assign io.m_fire   = ks_q[4] | ks_q[13] | io.joy1[4] | io.joy2[4];
  assign io.m_start1 = ks_q[5] | io.joy1[5] | io.joy2[5];
  assign io.m_start2 = ks_q[6] | io.joy1[6] | io.joy2[6];

  // ---------------------------------------------------------------------------
  // Coin shaper: fixed-width pulse, then a mandatory low gap, then wait for the
  // source to drop so a held coin only ever produces one pulse.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_ARM   = 2'd3
  } coin_state_t;

  coin_state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        coin_raw;
  logic        coin_out;

  assign coin_raw = ks_q[7] | ks_q[8] | io.joy1[7] | io.joy2[7];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_raw) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      S_PULSE: begin
        coin_out = 1'b1;
        // Counter holds the remaining cycles after this one; zero means this
        // is the last high cycle.
        if (cnt_q == 24'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 24'd0) begin
          state_d = S_ARM;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_ARM: begin
        if (!coin_raw) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign io.m_coin = coin_out;

endmodule
